multicycle_controller: RTL



---
 rtl/riscv_pkg.sv | 76 +++++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: controller states,
// ALU operation codes, opcodes and datapath mux encodings.
package riscv_pkg;

  // Controller states; 13 states fit in 4 bits.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    LUI      = 4'd8,
    ALUWB    = 4'd9,
    BRANCH   = 4'd10,
    JALRADR  = 4'd11,
    JAL      = 4'd12
  } state_t;

  // Which decode table the ALU decoder applies this cycle.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_RTYPE  = 2'd1,
    CLS_ITYPE  = 2'd2,
    CLS_BRANCH = 2'd3
  } alu_class_t;

  // ALU operation codes (0101, 0110, 1100-1111 are never issued).
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  // RV32I major opcodes (IR[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: maps the instruction class,
// funct3 and funct7b5 onto the 4-bit ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_class_t  cls_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [3:0]  alu_ctrl_o
);

  // Select the ALU code; unlisted combinations fall back to ADD.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      CLS_RTYPE, CLS_ITYPE: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = ((cls_i == CLS_RTYPE) && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        // beq/bne compare by subtraction, blt/bge signed, bltu/bgeu unsigned.
        case (funct3_i[2:1])
          2'b00:   alu_ctrl_o = ALU_SUB;
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback, drives every datapath select and write
// enable, and resolves branches from the ALU flags.
//
// Memory handshake: the controller presents an access (fetch address,
// load address, or store with mem_write high) and holds it, together with
// all selects, every cycle until mem_ready is seen high; the cycle in which
// mem_ready is high is the cycle the access completes, and the FSM then
// advances. mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        mem_ready,
  input  logic        zero,
  input  logic        less_than,
  input  logic        less_than_u,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        illegal_op,
  output state_t      dbg_state_o
);

  state_t     state_q, state_d;
  alu_class_t alu_cls;
  logic       ir_write_d, pc_write_d, reg_write_d, mem_write_d, illegal_d;
  logic       taken;

  // State register; reset returns the FSM to its reset state.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Next-state logic and all datapath controls for the current state.
  always_comb begin
    state_d     = state_q;
    alu_cls     = CLS_ADD;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_I;
    adr_src     = 1'b0;
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    illegal_d   = 1'b0;
    taken       = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_d = mem_ready;
        pc_write_d = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Precompute old_pc + imm into ALUOut for branch/jal/auipc targets.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_BRANCH: imm_src = IMM_B;
          OP_JAL:    imm_src = IMM_J;
          OP_AUIPC:  imm_src = IMM_U;
          default:   imm_src = IMM_I;
        endcase
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALRADR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = ALUWB;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src  = RES_MEMDATA;
        reg_write_d = 1'b1;
        state_d     = FETCH;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_d = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        alu_cls   = CLS_RTYPE;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        alu_cls   = CLS_ITYPE;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = ALUWB;
      end
      LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_d   = ALUWB;
      end
      ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_d = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        // The target was latched in DECODE; here the ALU only compares.
        alu_cls    = CLS_BRANCH;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  taken = zero;
          3'b001:  taken = ~zero;
          3'b100:  taken = less_than;
          3'b101:  taken = ~less_than;
          3'b110:  taken = less_than_u;
          3'b111:  taken = ~less_than_u;
          default: illegal_d = 1'b1;
        endcase
        pc_write_d = taken;
        state_d    = FETCH;
      end
      JALRADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        state_d   = JAL;
      end
      JAL: begin
        // PC takes the target in ALUOut while the ALU forms old_pc + 4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write_d = 1'b1;
        state_d    = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls_i      (alu_cls),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (alu_ctrl)
  );

  // Reset aborts any instruction in flight: no side effects that cycle.
  assign ir_write    = ir_write_d  & ~reset;
  assign pc_write    = pc_write_d  & ~reset;
  assign reg_write   = reg_write_d & ~reset;
  assign mem_write   = mem_write_d & ~reset;
  assign illegal_op  = illegal_d   & ~reset;
  assign dbg_state_o = state_q;

endmodule
